// File: rtl/div_unit.sv
// ---------------------------------------------------------------------------
// div_unit
// Multi-cycle restoring divider for the execute stage. A start pulse in IDLE
// captures the operands; one quotient bit is produced per cycle over WIDTH
// iterations. A final cycle applies the sign corrections and registers the
// result together with a one-cycle done pulse.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high; clears all state
//   start      request a division (only honoured in IDLE)
//   is_signed  1 = two's-complement divide, 0 = unsigned divide
//   dividend   dividend operand, sampled with start
//   divisor    divisor operand, sampled with start
//   busy       high from the accepting edge until the result edge
//   done       one-cycle pulse, results valid while high
//   quotient   registered quotient, held until the next result
//   remainder  registered remainder, held until the next result
// ---------------------------------------------------------------------------
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t           state;
    state_t           next_state;

    logic [CW-1:0]    count;
    logic [WIDTH-1:0] part_rem;     // partial remainder
    logic [WIDTH-1:0] dvd_q;        // dividend bits shift out, quotient bits shift in
    logic [WIDTH-1:0] dvs_mag;      // divisor magnitude
    logic             signed_mode;
    logic             dividend_neg;
    logic             divisor_neg;
    logic             div_zero;

    logic             in_dividend_neg;
    logic             in_divisor_neg;
    logic [WIDTH-1:0] in_dividend_mag;
    logic [WIDTH-1:0] in_divisor_mag;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic             trial_ok;

    logic             neg_q;
    logic             neg_r;
    logic [WIDTH-1:0] q_final;
    logic [WIDTH-1:0] r_final;

    // Operand magnitudes for the accepting edge; unsigned mode passes raw values.
    always_comb begin
        in_dividend_neg = is_signed & dividend[WIDTH-1];
        in_divisor_neg  = is_signed & divisor[WIDTH-1];
        if (in_dividend_neg) begin
            in_dividend_mag = {WIDTH{1'b0}} - dividend;
        end else begin
            in_dividend_mag = dividend;
        end
        if (in_divisor_neg) begin
            in_divisor_mag = {WIDTH{1'b0}} - divisor;
        end else begin
            in_divisor_mag = divisor;
        end
    end

    // One restoring step: shift in the next dividend bit and trial-subtract
    // at WIDTH+1 bits so the borrow shows up as the sign bit.
    always_comb begin
        shifted  = {part_rem, dvd_q[WIDTH-1]};
        trial    = shifted - {1'b0, dvs_mag};
        trial_ok = ~trial[WIDTH];
    end

    // Sign correction of the final magnitudes. Divide-by-zero forces an
    // all-ones quotient; the remainder already equals the original dividend
    // because every trial subtraction of zero succeeds. The most-negative / -1
    // case wraps to the most-negative quotient without special handling.
    always_comb begin
        neg_q = signed_mode & (dividend_neg ^ divisor_neg);
        neg_r = signed_mode & dividend_neg;
        if (div_zero) begin
            q_final = {WIDTH{1'b1}};
        end else if (neg_q) begin
            q_final = {WIDTH{1'b0}} - dvd_q;
        end else begin
            q_final = dvd_q;
        end
        if (neg_r) begin
            r_final = {WIDTH{1'b0}} - part_rem;
        end else begin
            r_final = part_rem;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = RUN;
                end else begin
                    next_state = IDLE;
                end
            end
            RUN: begin
                if (count == {CW{1'b0}}) begin
                    next_state = FINISH;
                end else begin
                    next_state = RUN;
                end
            end
            FINISH: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count        <= {CW{1'b0}};
            part_rem     <= {WIDTH{1'b0}};
            dvd_q        <= {WIDTH{1'b0}};
            dvs_mag      <= {WIDTH{1'b0}};
            signed_mode  <= 1'b0;
            dividend_neg <= 1'b0;
            divisor_neg  <= 1'b0;
            div_zero     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            quotient     <= {WIDTH{1'b0}};
            remainder    <= {WIDTH{1'b0}};
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        signed_mode  <= is_signed;
                        dividend_neg <= in_dividend_neg;
                        divisor_neg  <= in_divisor_neg;
                        div_zero     <= (divisor == {WIDTH{1'b0}});
                        dvd_q        <= in_dividend_mag;
                        dvs_mag      <= in_divisor_mag;
                        part_rem     <= {WIDTH{1'b0}};
                        count        <= CW'(WIDTH - 1);
                        busy         <= 1'b1;
                    end
                end
                RUN: begin
                    if (trial_ok) begin
                        part_rem <= trial[WIDTH-1:0];
                    end else begin
                        part_rem <= shifted[WIDTH-1:0];
                    end
                    dvd_q <= {dvd_q[WIDTH-2:0], trial_ok};
                    if (count != {CW{1'b0}}) begin
                        count <= count - CW'(1);
                    end
                end
                FINISH: begin
                    quotient  <= q_final;
                    remainder <= r_final;
                    done      <= 1'b1;
                    busy      <= 1'b0;
                end
                default: begin
                    busy <= 1'b0;
                    done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// ---------------------------------------------------------------------------
// tb_div_unit
// Directed bench for div_unit: a table of operand/result records applied in a
// loop, followed by hand-written sequences for start-while-busy, restart on
// the done cycle, and asynchronous reset in the middle of a division.
// ---------------------------------------------------------------------------
module tb_div_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic        is_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;

    int checks = 0;
    int errors = 0;

    logic [31:0] prev_q = 32'd0;
    logic [31:0] prev_r = 32'd0;

    typedef struct {
        logic        s;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
    } vec_t;

    vec_t vecs [12];

    div_unit #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .is_signed (is_signed),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic launch(input logic s, input logic [31:0] a, input logic [31:0] b);
        is_signed = s;
        dividend  = a;
        divisor   = b;
        start     = 1'b1;
    endtask

    // Called on a falling edge with start already driven. Waits for done,
    // optionally injecting a 20/6 start after 'inject' edges, and checks the
    // result, latency, busy width and output hold. Returns on the done cycle.
    task automatic collect(input string name, input logic [31:0] eq,
                           input logic [31:0] er, input int inject);
        int  edges;
        int  busy_cnt;
        bit  hold_bad;
        edges    = 0;
        busy_cnt = 0;
        hold_bad = 1'b0;
        @(posedge clk);
        @(negedge clk);
        forever begin
            if (done === 1'b1) break;
            if (busy === 1'b1) busy_cnt++;
            if (quotient !== prev_q || remainder !== prev_r) hold_bad = 1'b1;
            if (edges >= 40) break;
            start = (edges == inject);
            if (edges == inject) begin
                is_signed = 1'b0;
                dividend  = 32'd20;
                divisor   = 32'd6;
            end
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        start = 1'b0;
        chk({name, " done"},      {31'd0, done},      32'd1);
        chk({name, " latency"},   edges,              32'd33);
        chk({name, " busy_cnt"},  busy_cnt,           32'd33);
        chk({name, " busy_low"},  {31'd0, busy},      32'd0);
        chk({name, " hold"},      {31'd0, hold_bad},  32'd0);
        chk({name, " quotient"},  quotient,           eq);
        chk({name, " remainder"}, remainder,          er);
        prev_q = eq;
        prev_r = er;
    endtask

    // One cycle after done: pulse must be gone, results held.
    task automatic check_pulse(input string name);
        @(negedge clk);
        chk({name, " done_pulse"}, {31'd0, done}, 32'd0);
        chk({name, " q_held"},     quotient,      prev_q);
    endtask

    initial begin
        vecs[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2};
        vecs[1]  = '{1'b1, 32'hFFFF_FFF9,  32'h0000_0002,  32'hFFFF_FFFD,  32'hFFFF_FFFF};
        vecs[2]  = '{1'b1, 32'h0000_0007,  32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'h0000_0001};
        vecs[3]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'h0000_0000};
        vecs[4]  = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0000_0000,  32'h8000_0000};
        vecs[5]  = '{1'b0, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5};
        vecs[6]  = '{1'b1, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5};
        vecs[7]  = '{1'b1, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFFB};
        vecs[8]  = '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0};
        vecs[9]  = '{1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE};
        vecs[10] = '{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0};
        vecs[11] = '{1'b0, 32'h1234_5678,  32'h0001_0000,  32'h0000_1234,  32'h0000_5678};

        reset     = 1'b1;
        start     = 1'b0;
        is_signed = 1'b0;
        dividend  = 32'd0;
        divisor   = 32'd0;
        repeat (2) @(negedge clk);
        chk("reset busy",      {31'd0, busy}, 32'd0);
        chk("reset done",      {31'd0, done}, 32'd0);
        chk("reset quotient",  quotient,      32'd0);
        chk("reset remainder", remainder,     32'd0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle busy", {31'd0, busy}, 32'd0);

        // Table of independent operations.
        for (int i = 0; i < 12; i++) begin
            launch(vecs[i].s, vecs[i].a, vecs[i].b);
            collect($sformatf("vec%0d", i), vecs[i].q, vecs[i].r, -1);
            check_pulse($sformatf("vec%0d", i));
        end

        // start while busy is ignored.
        launch(1'b0, 32'd9, 32'd3);
        collect("ignored_start", 32'd3, 32'd0, 5);
        check_pulse("ignored_start");

        // Restart on the done cycle: no dead cycle between operations.
        launch(1'b0, 32'd100, 32'd7);
        collect("first_op", 32'd14, 32'd2, -1);
        launch(1'b0, 32'd20, 32'd6);
        collect("restart", 32'd3, 32'd2, -1);
        check_pulse("restart");

        // Asynchronous reset in the middle of the iterations.
        launch(1'b0, 32'd100, 32'd7);
        @(posedge clk);
        #1 start = 1'b0;
        repeat (16) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("midreset busy",      {31'd0, busy}, 32'd0);
        chk("midreset done",      {31'd0, done}, 32'd0);
        chk("midreset quotient",  quotient,      32'd0);
        chk("midreset remainder", remainder,     32'd0);
        @(negedge clk);
        reset  = 1'b0;
        prev_q = 32'd0;
        prev_r = 32'd0;
        repeat (2) @(negedge clk);
        chk("postreset busy", {31'd0, busy}, 32'd0);
        chk("postreset done", {31'd0, done}, 32'd0);

        // Fresh operation after reset runs with full latency.
        launch(1'b0, 32'd1000, 32'd10);
        collect("after_reset", 32'd100, 32'd0, -1);
        check_pulse("after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/div_unit.md
# div_unit

Multi-cycle iterative integer divider for the execute stage; the subtractive counterpart to the datapath's single-cycle adder. Accepts a dividend/divisor pair on a start pulse, runs a restoring shift-subtract loop one quotient bit per cycle, and returns quotient (LO) and remainder (HI) with a one-cycle done pulse. The hazard unit holds the pipeline while busy is high.

## Interface

- WIDTH, 32, operand/result width in bits.

- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  request a division; sampled only in IDLE.
- is_signed  in  1  1 = two's-complement (DIV), 0 = unsigned (DIVU); sampled with start.
- dividend  in  WIDTH  sampled with start.
- divisor  in  WIDTH  sampled with start.
- busy  out  1  high from the accepting edge until the result edge.
- done  out  1  one-cycle pulse; results are valid while high.
- quotient  out  WIDTH  registered; held until the next result edge.
- remainder  out  WIDTH  registered; held until the next result edge.

## Operation

- States: IDLE, RUN, FINISH.
- IDLE with start=1: latch is_signed, the divide-by-zero flag (divisor==0), and the operand signs. Load magnitude registers with |dividend| and |divisor|; unsigned mode uses the raw values. Clear the partial remainder. Set the iteration count to WIDTH-1 and go to RUN.
- IDLE with start=0: stay in IDLE.
- RUN, per cycle:
  - Shift {partial remainder, dividend} left by 1.
  - Trial-subtract the divisor magnitude from the partial remainder at WIDTH+1 bits.
  - If the result is non-negative, keep the difference and set the quotient LSB to 1; otherwise restore and set it to 0.
  - When count reaches 0, go to FINISH; otherwise decrement count.
- FINISH:
  - Signed mode: negate the quotient when the operand signs differ; negate the remainder when the dividend is negative.
  - Register quotient/remainder, pulse done, return to IDLE.
- Divide by zero: quotient = all ones, remainder = original dividend, for both signed and unsigned. Latency is unchanged.
- Signed overflow (most-negative / -1): quotient = most-negative value, remainder = 0. This falls out of magnitude arithmetic with WIDTH-bit wrap and needs no special case.
- start while busy: ignored; latched operands are unaffected.
- reset at any time, including mid-RUN: the next state is IDLE; busy, done, quotient and remainder go to 0 and the iteration count clears. No partial result is emitted.

## Timing

- Reset values: busy=0, done=0, quotient=0, remainder=0, state=IDLE.
- Edge E0 accepts start; busy=1 from E0 to E0+WIDTH+1.
- Edges E0+1 .. E0+WIDTH: iterations.
- Edge E0+WIDTH+1 (E0+33 for WIDTH=32): results registered, done=1, busy=0.
- done stays high for exactly one cycle.
- A start asserted during the done cycle is accepted at the next edge, giving back-to-back operations with no dead cycle.
- Outputs change only at FINISH or on reset.

## Test plan

- Unsigned 100 / 7, start for one cycle -> done exactly 33 edges later; quotient=14, remainder=2; busy high for 33 cycles.
- Signed -7 / 2 (0xFFFFFFF9 / 0x2) -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF. Signed 7 / -2 -> quotient=0xFFFFFFFD, remainder=1.
- 0x80000000 / 0xFFFFFFFF:
  - signed -> quotient=0x80000000, remainder=0;
  - unsigned -> quotient=0, remainder=0x80000000.
- Divide by zero, 5 / 0 in both modes -> quotient=0xFFFFFFFF, remainder=5, done at the same 33-edge latency.
- start with 9/3 then 20/6 asserted 5 cycles later while busy -> the second start is ignored; result is q=3, r=0.
- Restart on the done cycle with 20/6 -> second result q=3, r=2 exactly 33 edges after it.
- Reset asserted asynchronously at iteration 16 -> busy/done/quotient/remainder immediately 0.
- Fresh start after that reset -> correct result (1000/10 gives q=100, r=0) with full 33-edge latency.
